// File: rtl/adder_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// adder_pkg: shared op encodings, default geometry and saturation constants for pipelined_addsub.
// Rev 1.0
package adder_pkg;

   localparam int DEFAULT_WIDTH     = 32;
   localparam int DEFAULT_SEG_WIDTH = 8;

   // Upper bound on WIDTH supported by the saturation helpers below.
   localparam int MAX_WIDTH = 512;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Most positive w-bit two's-complement value, zero-extended to MAX_WIDTH.
   function automatic logic [MAX_WIDTH-1:0] SMAX(input int w);
      logic [MAX_WIDTH-1:0] v;
      v = '0;
      for (int i = 0; i < w - 1; i++) begin
         v[i] = 1'b1;
      end
      return v;
   endfunction

   // Most negative w-bit two's-complement value, zero-extended to MAX_WIDTH.
   function automatic logic [MAX_WIDTH-1:0] SMIN(input int w);
      logic [MAX_WIDTH-1:0] v;
      v = '0;
      v[w-1] = 1'b1;
      return v;
   endfunction

endpackage : adder_pkg
`default_nettype wire

// File: rtl/pipelined_addsub_rca_segment.sv
`timescale 1ns/1ps
`default_nettype none
// rca_segment: combinational SEG_WIDTH-bit ripple-carry adder slice.
// Rev 1.0
module rca_segment
   import adder_pkg::*;
#(
   parameter int SEG_WIDTH = DEFAULT_SEG_WIDTH
) (
   input  logic [SEG_WIDTH-1:0] a,
   input  logic [SEG_WIDTH-1:0] b,
   input  logic                 cin,
   output logic [SEG_WIDTH-1:0] s,
   output logic                 cout
);

   logic [SEG_WIDTH:0] carry;

   always_comb begin
      carry    = '0;
      s        = '0;
      carry[0] = cin;
      for (int i = 0; i < SEG_WIDTH; i++) begin
         s[i]       = a[i] ^ b[i] ^ carry[i];
         carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = carry[SEG_WIDTH];

endmodule : rca_segment
`default_nettype wire

// File: rtl/pipelined_addsub.sv
`timescale 1ns/1ps
`default_nettype none
// pipelined_addsub: segmented, pipelined two's-complement add/sub with overflow,
// optional signed saturation and a valid/ready stream handshake. Rev 1.0
module pipelined_addsub
   import adder_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int SEG_WIDTH = DEFAULT_SEG_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             op,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STAGES = WIDTH / SEG_WIDTH;

   localparam logic [MAX_WIDTH-1:0] SMAX_FULL = SMAX(WIDTH);
   localparam logic [MAX_WIDTH-1:0] SMIN_FULL = SMIN(WIDTH);
   localparam logic [WIDTH-1:0]     SAT_MAX   = SMAX_FULL[WIDTH-1:0];
   localparam logic [WIDTH-1:0]     SAT_MIN   = SMIN_FULL[WIDTH-1:0];

   // Stage k registers: skewed operands, partial sum, carry, valid, sat flag.
   logic [WIDTH-1:0] a_q   [STAGES];
   logic [WIDTH-1:0] bp_q  [STAGES];
   logic [WIDTH-1:0] s_q   [STAGES];
   logic             c_q   [STAGES];
   logic             v_q   [STAGES];
   logic             sat_q [STAGES];
   logic             ovf_q;

   // Stage k inputs: port values for stage 0, previous stage registers otherwise.
   logic [WIDTH-1:0] x_a   [STAGES];
   logic [WIDTH-1:0] x_bp  [STAGES];
   logic [WIDTH-1:0] x_s   [STAGES];
   logic             x_c   [STAGES];
   logic             x_v   [STAGES];
   logic             x_sat [STAGES];

   logic stall;
   logic advance;

   assign stall    = out_valid && !out_ready;
   assign advance  = !stall;
   assign in_ready = advance;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [SEG_WIDTH-1:0] seg_s;
      logic                 seg_c;
      logic [WIDTH-1:0]     nxt_s;
      logic [WIDTH-1:0]     res;

      if (k == 0) begin : g_first
         // Subtraction becomes a + ~b + 1; the inversion and forced carry happen here.
         assign x_a[0]   = a;
         assign x_bp[0]  = (op == OP_SUB) ? ~b : b;
         assign x_s[0]   = '0;
         assign x_c[0]   = (op == OP_SUB) ? 1'b1 : cin;
         assign x_v[0]   = in_valid;
         assign x_sat[0] = sat;
      end else begin : g_next
         assign x_a[k]   = a_q[k-1];
         assign x_bp[k]  = bp_q[k-1];
         assign x_s[k]   = s_q[k-1];
         assign x_c[k]   = c_q[k-1];
         assign x_v[k]   = v_q[k-1];
         assign x_sat[k] = sat_q[k-1];
      end

      rca_segment #(
         .SEG_WIDTH (SEG_WIDTH)
      ) u_seg (
         .a    (x_a[k][k*SEG_WIDTH +: SEG_WIDTH]),
         .b    (x_bp[k][k*SEG_WIDTH +: SEG_WIDTH]),
         .cin  (x_c[k]),
         .s    (seg_s),
         .cout (seg_c)
      );

      always_comb begin
         nxt_s                               = x_s[k];
         nxt_s[k*SEG_WIDTH +: SEG_WIDTH]     = seg_s;
      end

      if (k == STAGES - 1) begin : g_last
         logic raw_ovf;

         // Overflow: operands share a sign that the raw result does not.
         assign raw_ovf = (x_a[k][WIDTH-1] == x_bp[k][WIDTH-1]) &&
                          (nxt_s[WIDTH-1] != x_a[k][WIDTH-1]);
         assign res     = (x_sat[k] && raw_ovf) ?
                          (x_a[k][WIDTH-1] ? SAT_MIN : SAT_MAX) : nxt_s;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q <= 1'b0;
            end else if (advance) begin
               ovf_q <= raw_ovf;
            end
         end
      end else begin : g_mid
         assign res = nxt_s;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            a_q[k]   <= '0;
            bp_q[k]  <= '0;
            s_q[k]   <= '0;
            c_q[k]   <= 1'b0;
            v_q[k]   <= 1'b0;
            sat_q[k] <= 1'b0;
         end else if (advance) begin
            a_q[k]   <= x_a[k];
            bp_q[k]  <= x_bp[k];
            s_q[k]   <= res;
            c_q[k]   <= seg_c;
            v_q[k]   <= x_v[k];
            sat_q[k] <= x_sat[k];
         end
      end
   end

   assign out_valid = v_q[STAGES-1];
   assign sum       = s_q[STAGES-1];
   assign cout      = c_q[STAGES-1];
   assign ovf       = ovf_q;

endmodule : pipelined_addsub
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`timescale 1ns/1ps
`default_nettype none
// tb_pipelined_addsub: table-driven directed bench for pipelined_addsub (default 32/8 geometry).
// Rev 1.0
module tb_pipelined_addsub;

   localparam int W = 32;
   localparam int N = 13;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         op;
      logic         sat;
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } vec_t;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         op;
   logic         sat;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int errors = 0;
   int checks = 0;

   vec_t vecs [N];

   pipelined_addsub #(
      .WIDTH     (W),
      .SEG_WIDTH (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .op        (op),
      .sat       (sat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      in_valid = 1'b1;
      a        = v.a;
      b        = v.b;
      cin      = v.cin;
      op       = v.op;
      sat      = v.sat;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      cin      = 1'b0;
      op       = 1'b0;
      sat      = 1'b0;
   endtask

   task automatic expect_res(input string tag, input int idx);
      check($sformatf("%s_valid[%0d]", tag, idx), out_valid, 1'b1);
      check($sformatf("%s_sum[%0d]", tag, idx), sum, vecs[idx].s);
      check($sformatf("%s_cout[%0d]", tag, idx), cout, vecs[idx].co);
      check($sformatf("%s_ovf[%0d]", tag, idx), ovf, vecs[idx].ov);
   endtask

   initial begin
      //          a             b             cin   op    sat   sum           cout  ovf
      vecs[0]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
      vecs[1]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1};
      vecs[2]  = '{32'hFFFFFFCE, 32'hFFFFFF9C, 1'b1, 1'b0, 1'b0, 32'hFFFFFF6B, 1'b1, 1'b0};
      vecs[3]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'h80000000, 1'b1, 1'b1};
      vecs[4]  = '{32'h00000064, 32'h000000C8, 1'b1, 1'b1, 1'b0, 32'hFFFFFF9C, 1'b0, 1'b0};
      vecs[5]  = '{32'hFFFFD96C, 32'hFFFFEAC8, 1'b0, 1'b1, 1'b0, 32'hFFFFEEA4, 1'b0, 1'b0};
      vecs[6]  = '{32'h000004D2, 32'hFFFFE9D2, 1'b1, 1'b0, 1'b0, 32'hFFFFEEA5, 1'b0, 1'b0};
      vecs[7]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0};
      vecs[8]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
      vecs[9]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b1, 32'h80000000, 1'b1, 1'b1};
      vecs[10] = '{32'h00000005, 32'h00000005, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
      vecs[11] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
      vecs[12] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1};

      rst_n     = 1'b0;
      out_ready = 1'b0;
      idle();

      // Reset state, with out_ready low so in_ready cannot come from out_ready.
      #12;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_sum", sum, 32'h0);
      check("rst_cout", cout, 1'b0);
      check("rst_ovf", ovf, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      // Back-to-back stream: results on N consecutive cycles, 4 cycles after first accept.
      out_ready = 1'b1;
      for (int j = 0; j < N + 6; j++) begin
         @(negedge clk);
         if (j >= 1) begin
            check($sformatf("tp_out_valid_cyc%0d", j), out_valid, (j >= 4 && j < N + 4));
            if (j >= 4 && j < N + 4) expect_res("tp", j - 4);
         end
         if (j < N) drive(vecs[j]);
         else idle();
         #1;
         check($sformatf("tp_in_ready_cyc%0d", j), in_ready, 1'b1);
      end

      // Backpressure: fill the pipe, stall 5 cycles with a pending request, then drain.
      out_ready = 1'b0;
      for (int j = 0; j < 14; j++) begin
         @(negedge clk);
         if (j < 4) begin
            check($sformatf("bp_fill_valid%0d", j), out_valid, 1'b0);
            drive(vecs[j]);
         end else if (j <= 8) begin
            expect_res($sformatf("bp_stall%0d", j), 0);
            drive(vecs[4]);
            #1;
            check($sformatf("bp_in_ready_stall%0d", j), in_ready, 1'b0);
            if (j == 8) begin
               out_ready = 1'b1;
               #1;
               check("bp_in_ready_release", in_ready, 1'b1);
            end
         end else if (j <= 12) begin
            expect_res("bp_drain", j - 8);
            idle();
         end else begin
            check("bp_drained_valid", out_valid, 1'b0);
         end
      end

      // Reset with operations in flight flushes them all.
      out_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         drive(vecs[2 + j]);
      end
      @(negedge clk);
      expect_res("pre_flush", 2);
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      check("flush_out_valid", out_valid, 1'b0);
      check("flush_sum", sum, 32'h0);
      check("flush_cout", cout, 1'b0);
      check("flush_ovf", ovf, 1'b0);
      check("flush_in_ready", in_ready, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         check($sformatf("post_rst_no_stale%0d", j), out_valid, 1'b0);
      end
      drive(vecs[6]);
      for (int j = 1; j <= 4; j++) begin
         @(negedge clk);
         idle();
         if (j < 4) check($sformatf("post_rst_lat%0d", j), out_valid, 1'b0);
         else expect_res("post_rst", 6);
      end
      @(negedge clk);
      check("post_rst_single", out_valid, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_pipelined_addsub
`default_nettype wire
